// File: rtl/bram_sdp_flush_if.sv
// Purpose : request/response bundle for the bram_sdp_flush simple-dual-port
//           RAM controller (one write port, one read port, flush/busy).
// Signals :
//   wen/waddr/wdata/wbe  write request, lane enables in wbe
//   ren/raddr            read request
//   rdata/rvalid         read response, rvalid pulses once per accepted read
//   flush                request to zero the whole array
//   busy                 clear engine running
// Handshake: there is no per-request ready. wen, ren and flush are single-cycle
//   requests sampled on every rising edge; each is accepted exactly when busy
//   is 0 in that cycle and silently dropped when busy is 1. An accepted read
//   yields exactly one rvalid pulse, in request order, L = 1 + OUT_REG edges
//   after the sampling edge.
// Modports: master drives requests (testbench/user), slave is the controller.
interface bram_sdp_flush_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int BE_WIDTH   = 2
);
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   wbe;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  flush;
  logic                  busy;

  modport master (
    output wen, waddr, wdata, wbe, ren, raddr, flush,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  wen, waddr, wdata, wbe, ren, raddr, flush,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/bram_sdp_flush.sv
// Purpose : parametrised simple-dual-port block RAM controller with per-lane
//           byte enables, optional output register, same-address write
//           bypass and a hardware clear engine (after reset and on flush).
// Ports   :
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        bram_sdp_flush_if.slave (requests in, rdata/rvalid/busy out)
//   dbg_state  current FSM state (0 = READY, 1 = CLEAR)
module bram_sdp_flush #(
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 10,
  parameter int BE_WIDTH       = 2,
  parameter int OUT_REG        = 0,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_sdp_flush_if.slave   bus,
  output logic              dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / BE_WIDTH;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_user;
  logic                  rd_user;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_merged;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign wr_user = (state == ST_READY) && bus.wen;
  assign rd_user = (state == ST_READY) && bus.ren;

  // Single physical write port: the clear engine owns it while clearing.
  always_comb begin
    mem_we    = '0;
    mem_addr  = bus.waddr;
    mem_wdata = bus.wdata;
    if (!rst_n) begin
      mem_we = '0;
    end else if (state == ST_CLEAR) begin
      mem_we    = '1;
      mem_addr  = cnt;
      mem_wdata = '0;
    end else if (bus.wen) begin
      mem_we = bus.wbe;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (mem_we[i]) mem[mem_addr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
    end
  end

  // Array read is read-first (old word); write-first behaviour is obtained
  // by overlaying the enabled lanes of a colliding write.
  always_comb begin
    rd_merged = mem[bus.raddr];
    if ((BYPASS != 0) && wr_user && (bus.waddr == bus.raddr)) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.wbe[i]) rd_merged[i*LW +: LW] = bus.wdata[i*LW +: LW];
      end
    end
  end

  // Control FSM plus first read stage. The read stage keeps draining while
  // clearing so reads issued before a flush complete with pre-clear data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      busy_q   <= (CLEAR_ON_RESET != 0);
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_user;
      if (rd_user) s1_data <= rd_merged;
      case (state)
        ST_READY: begin
          if (bus.flush) begin
            state  <= ST_CLEAR;
            busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          // Last address just written: cnt wraps back to 0 on its own.
          if (&cnt) begin
            state  <= ST_READY;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_READY;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rvalid_q;
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= s1_valid;
          if (s1_valid) rdata_q <= s1_data;
        end
      end
      assign bus.rvalid = rvalid_q;
      assign bus.rdata  = rdata_q;
    end else begin : g_no_out_reg
      assign bus.rvalid = s1_valid;
      assign bus.rdata  = s1_data;
    end
  endgenerate

  assign bus.busy  = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_bram_sdp_flush.sv
// Testbench for bram_sdp_flush. Two instances share one stimulus stream:
//   dut_a : OUT_REG=0, BYPASS=1 (latency 1, write-first)
//   dut_b : OUT_REG=1, BYPASS=0 (latency 2, read-first)
// A behavioural model (word array, clear-in-progress count, per-DUT queues
// of expected read results with their due edge) predicts every output.
module tb_bram_sdp_flush;
  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 16;
  localparam int LW    = DW / BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_sdp_flush_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW)) bus_a ();
  bram_sdp_flush_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW)) bus_b ();
  logic dbg_a, dbg_b;

  bram_sdp_flush #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW),
                   .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dbg_state(dbg_a));

  bram_sdp_flush #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW),
                   .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .dbg_state(dbg_b));

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_clr_left;
  int            edge_n = 0;
  bit            started = 0;
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];
  int            due_q_a[$];
  int            due_q_b[$];
  logic [DW-1:0] last_a, last_b;
  logic [DW-1:0] fill_val [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the rules of one rising edge to the model.
  task automatic model_edge(input bit r, input bit wen, input logic [AW-1:0] waddr,
                            input logic [DW-1:0] wdata, input logic [BW-1:0] wbe,
                            input bit ren, input logic [AW-1:0] raddr, input bit flush);
    logic [DW-1:0] old_w, new_w;
    edge_n++;
    if (!r) begin
      m_busy     = 1;
      m_clr_left = DEPTH;
      exp_q_a.delete(); due_q_a.delete();
      exp_q_b.delete(); due_q_b.delete();
      last_a = '0;
      last_b = '0;
      return;
    end
    if (m_busy) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
      if (m_clr_left == 0) m_busy = 0;
      return;
    end
    old_w = m_mem[waddr];
    new_w = old_w;
    for (int i = 0; i < BW; i++)
      if (wbe[i]) new_w[i*LW +: LW] = wdata[i*LW +: LW];
    if (ren) begin
      exp_q_a.push_back((wen && waddr == raddr) ? new_w : m_mem[raddr]);
      due_q_a.push_back(edge_n);
      exp_q_b.push_back(m_mem[raddr]);
      due_q_b.push_back(edge_n + 1);
    end
    if (wen) m_mem[waddr] = new_w;
    if (flush) begin
      m_busy     = 1;
      m_clr_left = DEPTH;
    end
  endtask

  task automatic check_outputs();
    bit va, vb;
    va = (due_q_a.size() > 0) && (due_q_a[0] == edge_n);
    vb = (due_q_b.size() > 0) && (due_q_b[0] == edge_n);
    if (va) begin last_a = exp_q_a.pop_front(); void'(due_q_a.pop_front()); end
    if (vb) begin last_b = exp_q_b.pop_front(); void'(due_q_b.pop_front()); end
    check("a_rvalid", 32'(bus_a.rvalid), 32'(va));
    check("a_rdata",  32'(bus_a.rdata),  32'(last_a));
    check("b_rvalid", 32'(bus_b.rvalid), 32'(vb));
    check("b_rdata",  32'(bus_b.rdata),  32'(last_b));
    check("a_busy",   32'(bus_a.busy),   32'(m_busy));
    check("b_busy",   32'(bus_b.busy),   32'(m_busy));
    check("a_state",  32'(dbg_a),        32'(m_busy));
    check("b_state",  32'(dbg_b),        32'(m_busy));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit wen, input logic [AW-1:0] waddr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] wbe,
                      input bit ren, input logic [AW-1:0] raddr, input bit flush);
    @(negedge clk);
    if (started) check_outputs();
    rst_n       = r;
    bus_a.wen   = wen;   bus_b.wen   = wen;
    bus_a.waddr = waddr; bus_b.waddr = waddr;
    bus_a.wdata = wdata; bus_b.wdata = wdata;
    bus_a.wbe   = wbe;   bus_b.wbe   = wbe;
    bus_a.ren   = ren;   bus_b.ren   = ren;
    bus_a.raddr = raddr; bus_b.raddr = raddr;
    bus_a.flush = flush; bus_b.flush = flush;
    model_edge(r, wen, waddr, wdata, wbe, ren, raddr, flush);
    started = 1;
    @(posedge clk);
  endtask

  task automatic idle();
    step(1, 0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    step(1, 1, a, d, be, 0, '0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1, 0, '0, '0, '0, 1, a, 0);
  endtask

  // Counts cycles with busy high, starting just after the edge that raised it.
  task automatic busy_len(input string tag);
    int n;
    n = 0;
    #1;
    while (bus_a.busy === 1'b1 && n < 40) begin
      n++;
      idle();
      #1;
    end
    check(tag, 32'(n), 32'd16);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_a.wen = 0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.wbe = '0;
    bus_a.ren = 0; bus_a.raddr = '0; bus_a.flush = 0;
    bus_b.wen = 0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.wbe = '0;
    bus_b.ren = 0; bus_b.raddr = '0; bus_b.flush = 0;
    last_a = '0; last_b = '0;
    m_busy = 1; m_clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

    // Reset, then the clear engine runs for exactly DEPTH cycles.
    step(0, 0, '0, '0, '0, 0, '0, 0);
    step(0, 0, '0, '0, '0, 0, '0, 0);
    busy_len("reset_busy_len");
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(); idle();

    // Lane enables.
    wr(5, 18'h3FFFF, 2'b11);
    wr(5, 18'h00000, 2'b01);
    rd(5);
    idle();
    #1 check("be_a", 32'(bus_a.rdata), 32'h3FE00);
    check("be_b", 32'(bus_b.rdata), 32'h3FE00);
    wr(5, 18'h00000, 2'b00);
    rd(5);
    idle();
    #1 check("be_none_b", 32'(bus_b.rdata), 32'h3FE00);

    // Same-address collision.
    wr(3, 18'h00111, 2'b11);
    step(1, 1, 3, 18'h2AAAA, 2'b11, 1, 3, 0);
    idle();
    #1 check("coll_a", 32'(bus_a.rdata), 32'h2AAAA);
    check("coll_b", 32'(bus_b.rdata), 32'h00111);
    rd(3);
    idle();
    #1 check("after_coll_b", 32'(bus_b.rdata), 32'h2AAAA);
    // Partial-lane collision.
    step(1, 1, 3, 18'h15555, 2'b10, 1, 3, 0);
    idle(); idle();

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) rd(AW'(i + 2));
    idle(); idle(); idle();

    // Flush with a same-cycle read of address 7; requests during busy dropped.
    for (int i = 0; i < DEPTH; i++) begin
      fill_val[i] = DW'($urandom_range(1, (1 << DW) - 1));
      wr(AW'(i), fill_val[i], 2'b11);
    end
    step(1, 0, '0, '0, '0, 1, 7, 1);
    #1 check("flush_rd7_a", 32'(bus_a.rdata), 32'(fill_val[7]));
    for (int i = 0; i < 16; i++)
      step(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
           2'b11, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 0);
    #1 check("flush_done", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(); idle();

    // Reset in the middle of a clear restarts it from address 0.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom_range(1, 255)), 2'b11);
    step(1, 0, '0, '0, '0, 0, '0, 1);
    for (int i = 0; i < 8; i++) idle();
    step(0, 0, '0, '0, '0, 0, '0, 0);
    busy_len("midclear_busy_len");
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(); idle();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 149) != 0),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
           BW'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)),
           1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 20; i++) idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
